// File: rtl/iiitb_vend_ctrl.sv
// ============================================================================
// Module      : iiitb_vend_ctrl
// Description : Parametrised coin vending controller with credit, vend pulse,
//               coin-by-coin change handshake, cancel/refund and coin reject.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iiitb_vend_ctrl #(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [2:0]          coin,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                vend,
    output logic [2:0]          state,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    output logic [2:0]          change_coin,
    output logic                coin_reject
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_VEND    = 3'd2;
    localparam logic [2:0] S_CHANGE  = 3'd3;

    localparam logic [2:0] C_NICKEL  = 3'b001;
    localparam logic [2:0] C_DIME    = 3'b010;
    localparam logic [2:0] C_QUARTER = 3'b101;

    localparam logic [CREDIT_W-1:0] C_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C_MAX   = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] C_V1    = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] C_V2    = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] C_V5    = CREDIT_W'(5);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_next_credit;
    logic                r_reject;
    logic                w_next_reject;

    logic                w_coin_ok;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_accept;
    logic [CREDIT_W-1:0] w_vend_rem;
    logic [2:0]          w_chg_code;
    logic [CREDIT_W-1:0] w_chg_val;
    logic [CREDIT_W-1:0] w_chg_rem;

    // Coin decode and acceptance
    always_comb begin
        w_coin_ok  = 1'b1;
        w_coin_val = '0;
        case (coin)
            C_NICKEL:  w_coin_val = C_V1;
            C_DIME:    w_coin_val = C_V2;
            C_QUARTER: w_coin_val = C_V5;
            default:   w_coin_ok  = 1'b0;
        endcase
    end

    assign w_sum      = r_credit + w_coin_val;
    assign w_accept   = coin_valid && w_coin_ok && (w_sum <= C_MAX);
    assign w_vend_rem = r_credit - C_PRICE;

    // Largest coin that still fits in the outstanding credit
    always_comb begin
        if (r_credit >= C_V5) begin
            w_chg_code = C_QUARTER;
            w_chg_val  = C_V5;
        end else if (r_credit >= C_V2) begin
            w_chg_code = C_DIME;
            w_chg_val  = C_V2;
        end else begin
            w_chg_code = C_NICKEL;
            w_chg_val  = C_V1;
        end
    end

    assign w_chg_rem = r_credit - w_chg_val;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_credit <= w_next_credit;
            r_reject <= w_next_reject;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_credit = r_credit;
        w_next_reject = 1'b0;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                w_next_reject = coin_valid && !w_accept;
                // A completing coin beats a same-cycle cancel
                if (w_accept && (w_sum >= C_PRICE)) begin
                    w_next_state  = S_VEND;
                    w_next_credit = w_sum;
                end else if ((r_state == S_COLLECT) && cancel) begin
                    w_next_state  = S_CHANGE;
                    w_next_credit = w_accept ? w_sum : r_credit;
                end else if (w_accept) begin
                    w_next_state  = S_COLLECT;
                    w_next_credit = w_sum;
                end
            end
            S_VEND: begin
                w_next_reject = coin_valid;
                w_next_credit = w_vend_rem;
                w_next_state  = (w_vend_rem != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                w_next_reject = coin_valid;
                if (change_ack) begin
                    w_next_credit = w_chg_rem;
                    if (w_chg_rem == '0) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_next_credit = '0;
            end
        endcase
    end

    always_comb begin
        vend         = (r_state == S_VEND);
        change_valid = (r_state == S_CHANGE);
        change_coin  = (r_state == S_CHANGE) ? w_chg_code : 3'b000;
    end

    assign state       = r_state;
    assign credit      = r_credit;
    assign coin_reject = r_reject;

endmodule

`default_nettype wire

// File: tb/tb_iiitb_vend_ctrl.sv
// Directed testbench for iiitb_vend_ctrl: default-price instance plus a
// PRICE=20/MAX_CREDIT=20 instance for the over-credit scenario.
`default_nettype none

module tb_iiitb_vend_ctrl;

    logic       clock = 1'b0;
    logic       reset, coin_valid, cancel, change_ack;
    logic [2:0] coin;
    logic       vend, change_valid, coin_reject;
    logic [2:0] state, change_coin;
    logic [5:0] credit;

    logic       b_reset, b_coin_valid, b_cancel, b_change_ack;
    logic [2:0] b_coin;
    logic       b_vend, b_change_valid, b_coin_reject;
    logic [2:0] b_state, b_change_coin;
    logic [5:0] b_credit;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    iiitb_vend_ctrl u_dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin(coin),
        .cancel(cancel), .change_ack(change_ack), .vend(vend), .state(state),
        .credit(credit), .change_valid(change_valid), .change_coin(change_coin),
        .coin_reject(coin_reject)
    );

    iiitb_vend_ctrl #(.PRICE(20), .MAX_CREDIT(20), .CREDIT_W(6)) u_dut20 (
        .clock(clock), .reset(b_reset), .coin_valid(b_coin_valid), .coin(b_coin),
        .cancel(b_cancel), .change_ack(b_change_ack), .vend(b_vend), .state(b_state),
        .credit(b_credit), .change_valid(b_change_valid), .change_coin(b_change_coin),
        .coin_reject(b_coin_reject)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put_coin(input logic [2:0] c);
        coin_valid = 1'b1;
        coin       = c;
        tick();
        coin_valid = 1'b0;
        coin       = 3'b000;
    endtask

    task automatic put_coin_b(input logic [2:0] c);
        b_coin_valid = 1'b1;
        b_coin       = c;
        tick();
        b_coin_valid = 1'b0;
        b_coin       = 3'b000;
    endtask

    // state, credit, vend, change_valid, change_coin, coin_reject
    task automatic check_all(input string tag, input int s, input int cr,
                             input int v, input int cv, input int cc, input int rj);
        check({tag, ".state"},  int'(state),        s);
        check({tag, ".credit"}, int'(credit),       cr);
        check({tag, ".vend"},   int'(vend),         v);
        check({tag, ".cvalid"}, int'(change_valid), cv);
        check({tag, ".ccoin"},  int'(change_coin),  cc);
        check({tag, ".reject"}, int'(coin_reject),  rj);
    endtask

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin = 3'b000; cancel = 1'b0; change_ack = 1'b0;
        b_reset = 1'b1; b_coin_valid = 1'b0; b_coin = 3'b000; b_cancel = 1'b0; b_change_ack = 1'b0;
        tick(); tick();
        reset = 1'b0; b_reset = 1'b0;
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // cancel in IDLE is ignored
        cancel = 1'b1; tick(); cancel = 1'b0;
        check_all("idle_cancel", 0, 0, 0, 0, 0, 0);

        // Exact payment: five nickels
        for (int i = 1; i <= 4; i++) begin
            put_coin(3'b001);
            check_all($sformatf("nick%0d", i), 1, i, 0, 0, 0, 0);
        end
        put_coin(3'b001);
        check_all("nick5", 2, 5, 1, 0, 0, 0);
        tick();
        check_all("exact_done", 0, 0, 0, 0, 0, 0);

        // Change return: dime, dime, quarter -> change of two dimes
        put_coin(3'b010); check_all("chg_d1", 1, 2, 0, 0, 0, 0);
        put_coin(3'b010); check_all("chg_d2", 1, 4, 0, 0, 0, 0);
        change_ack = 1'b1;
        put_coin(3'b101); check_all("chg_q",  2, 9, 1, 0, 0, 0);
        tick();           check_all("chg_c1", 3, 4, 0, 1, 2, 0);
        tick();           check_all("chg_c2", 3, 2, 0, 1, 2, 0);
        tick();           check_all("chg_end", 0, 0, 0, 0, 0, 0);
        change_ack = 1'b0;

        // Invalid coin in COLLECT, VEND and CHANGE
        put_coin(3'b010); check_all("inv_d",   1, 2, 0, 0, 0, 0);
        put_coin(3'b011); check_all("inv_col", 1, 2, 0, 0, 0, 1);
        tick();           check_all("inv_gap", 1, 2, 0, 0, 0, 0);
        put_coin(3'b101); check_all("inv_q",   2, 7, 1, 0, 0, 0);
        put_coin(3'b011); check_all("inv_vend", 3, 2, 0, 1, 2, 1);
        put_coin(3'b011); check_all("inv_chg", 3, 2, 0, 1, 2, 1);
        change_ack = 1'b1; tick(); change_ack = 1'b0;
        check_all("inv_end", 0, 0, 0, 0, 0, 0);

        // Cancel with stalled ack
        put_coin(3'b010); check_all("can_d", 1, 2, 0, 0, 0, 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        check_all("can_go", 3, 2, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("can_hold%0d", i), 3, 2, 0, 1, 2, 0);
        end
        change_ack = 1'b1; tick(); change_ack = 1'b0;
        check_all("can_end", 0, 0, 0, 0, 0, 0);

        // Nickel + cancel at credit 4: sale wins
        for (int i = 0; i < 4; i++) put_coin(3'b001);
        check_all("sim_c4", 1, 4, 0, 0, 0, 0);
        cancel = 1'b1; put_coin(3'b001); cancel = 1'b0;
        check_all("sim_vend", 2, 5, 1, 0, 0, 0);
        tick();
        check_all("sim_idle", 0, 0, 0, 0, 0, 0);

        // Nickel + cancel at credit 1: refund of one dime
        put_coin(3'b001); check_all("sim_c1", 1, 1, 0, 0, 0, 0);
        cancel = 1'b1; put_coin(3'b001); cancel = 1'b0;
        check_all("sim_refund", 3, 2, 0, 1, 2, 0);

        // Reset mid-CHANGE, with a coin in the same cycle
        reset = 1'b1; put_coin(3'b101); reset = 1'b0;
        check_all("rst_chg", 0, 0, 0, 0, 0, 0);

        // Over-credit on PRICE=20 / MAX_CREDIT=20 instance
        put_coin_b(3'b101); check("oc_q1", int'(b_credit), 5);
        put_coin_b(3'b101); check("oc_q2", int'(b_credit), 10);
        put_coin_b(3'b101); check("oc_q3", int'(b_credit), 15);
        put_coin_b(3'b010); check("oc_d",  int'(b_credit), 17);
        check("oc_d.state", int'(b_state), 1);
        put_coin_b(3'b101);
        check("oc_rej.credit", int'(b_credit), 17);
        check("oc_rej.reject", int'(b_coin_reject), 1);
        put_coin_b(3'b001);
        check("oc_n.credit", int'(b_credit), 18);
        check("oc_n.reject", int'(b_coin_reject), 0);
        put_coin_b(3'b010);
        check("oc_vend.credit", int'(b_credit), 20);
        check("oc_vend.vend",   int'(b_vend), 1);
        check("oc_vend.state",  int'(b_state), 2);
        tick();
        check("oc_end.credit", int'(b_credit), 0);
        check("oc_end.state",  int'(b_state), 0);
        check("oc_end.cvalid", int'(b_change_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iiitb_vend_ctrl.md
# iiitb_vend_ctrl

Parametrised successor to the team's fixed-price coin vending FSM: accumulates credit from nickels, dimes and quarters up to a configurable price, pulses `vend`, then returns change one physical coin at a time through a valid/ack handshake to the coin dispenser. Adds a cancel/refund path, invalid-coin and over-credit rejection, and an arbitrary price. Sits between the coin acceptor front-end and the product/coin dispensers.

## Interface
- `PRICE`, default 5: product price in 5-cent units; 5 means 25 cents. Must be at least 1.
- `MAX_CREDIT`, default 20: maximum credit held, in 5-cent units. Must be at least `PRICE`.
- `CREDIT_W`, default 6: credit register width. Requires MAX_CREDIT + 5 < 2^CREDIT_W.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `coin_valid`  in  1  a coin is presented this cycle; single-cycle strobe per coin.
- `coin`  in  3  coin code: 3'b001 nickel (1 unit), 3'b010 dime (2), 3'b101 quarter (5); all other codes are invalid.
- `cancel`  in  1  request refund of the current credit.
- `change_ack`  in  1  dispenser has taken `change_coin`.
- `vend`  out  1  product release; high for exactly one cycle per sale.
- `state`  out  3  FSM state: 0 IDLE, 1 COLLECT, 2 VEND, 3 CHANGE.
- `credit`  out  CREDIT_W  current credit in 5-cent units.
- `change_valid`  out  1  a change coin is offered.
- `change_coin`  out  3  coin to dispense, using the same encoding as `coin`.
- `coin_reject`  out  1  one-cycle pulse, the cycle after a coin is refused.

## Operation
- Reset: state IDLE; `credit`, `vend`, `change_valid`, `change_coin` and `coin_reject` all 0. Reset during any state, including mid-CHANGE, aborts the operation. Undispensed credit is discarded.
- Coin acceptance, IDLE or COLLECT only:
  - Let `sum = credit + value(coin)`.
  - Accept if the code is valid and `sum <= MAX_CREDIT`. Otherwise reject: `coin_reject` pulses and `credit` is unchanged.
- After an accepted coin:
  - If `sum >= PRICE`: next state VEND, `credit <= sum`.
  - Else: next state COLLECT, `credit <= sum`.
- IDLE: `credit` is 0. `cancel` is ignored.
- COLLECT, `cancel` asserted:
  - If the same-cycle coin completes the price, the sale wins and `cancel` is dropped.
  - Otherwise any same-cycle valid coin is added first, then the state goes to CHANGE with the full credit.
  - An invalid or over-limit coin in the same cycle is rejected; the refund still proceeds with the prior credit.
- VEND (one cycle): `vend` = 1 and `credit <= credit - PRICE`. Next state is CHANGE if the remainder is non-zero, else IDLE.
- CHANGE:
  - `change_valid` = 1.
  - `change_coin` selects the largest coin that fits: quarter if credit >= 5, else dime if >= 2, else nickel.
  - On `change_valid && change_ack`, `credit` drops by that coin's value. When it reaches 0, next state is IDLE and `change_valid` drops.
  - Without `change_ack`, `change_valid` and `change_coin` hold stable.
- Coins presented in VEND or CHANGE are rejected with a `coin_reject` pulse. `cancel` is ignored in VEND and CHANGE.
- All outputs are registered or decoded directly from registered state. No combinational path from inputs to outputs.

## Timing
- Coin sampled at edge t: `credit` updates at t+1. `coin_reject`, if any, is high during cycle t+1 only.
- Coin completing the price at edge t: `vend` is high during cycle t+1 and `state` = 2 (VEND).
- First change coin: `change_valid` rises one cycle after VEND.
- Each ack advances one coin per cycle. With `change_ack` held high, change of N coins completes in N cycles.
- `cancel` at edge t: `state` = 3 (CHANGE) and `change_valid` = 1 from cycle t+1.
- Back-to-back coins on consecutive cycles are all accepted while in IDLE or COLLECT.
- Throughput: the next sale can start on the first cycle back in IDLE.

## Test plan
- **Exact payment:** five nickels on consecutive cycles, default parameters -> `credit` 1,2,3,4,5. `vend` is one cycle high, `credit` goes to 0, state returns to IDLE, and `change_valid` never asserts.
- **Change return:** dime, dime, quarter -> `credit` 2, 4, 9, then vend and remainder 4. Dispensed as dime, dime with `change_ack` held high, then IDLE, `credit` 0.
- **Invalid coin:** code 3'b011 in COLLECT with `credit` 2 -> `coin_reject` pulse for one cycle, `credit` stays 2. The same code in VEND or CHANGE is also rejected.
- **Cancel with stalled ack:** dime then `cancel` -> CHANGE offering a dime. Withhold `change_ack` for 3 cycles: `change_valid` and `change_coin` = 3'b010 stay stable. Then ack -> IDLE.
- **Over-credit:** `PRICE`=20, `MAX_CREDIT`=20. Three quarters, then a dime -> `credit` 17. A further quarter is rejected (22 > 20). A nickel brings `credit` to 18; a dime then brings it to 20 and vends.
- **Simultaneous events and reset:**
  - Nickel plus `cancel` at `credit` 4 -> vend, no refund.
  - Nickel plus `cancel` at `credit` 1 -> refund of 2 units as dime.
  - Assert `reset` mid-CHANGE -> next cycle all outputs 0 and `state` = 0.
